// File: rtl/lru_replacement_array_pkg.sv
// Shared definitions for the LRU replacement array: flush FSM states, default geometry
// and the reset/flush age permutation (way 0 starts as LRU).
package lru_replacement_array_pkg;

    localparam int DEF_NUM_SETS = 64;
    localparam int DEF_NUM_WAYS = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_t;

    function automatic int init_age(input int way, input int num_ways);
        return num_ways - 1 - way;
    endfunction

endpackage

// File: rtl/lru_replacement_array_if.sv
// Touch/query/flush bundle of the LRU replacement array; master drives requests, slave answers.
// Victim is returned one cycle after a query; no backpressure, requests are dropped while busy.
interface lru_replacement_array_if
    import lru_replacement_array_pkg::*;
#(
    parameter int NUM_SETS = DEF_NUM_SETS,
    parameter int NUM_WAYS = DEF_NUM_WAYS
) ();
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);

    logic                touch_en;
    logic [SET_W-1:0]    touch_set;
    logic [WAY_W-1:0]    touch_way;
    logic                query_en;
    logic [SET_W-1:0]    query_set;
    logic [NUM_WAYS-1:0] query_valid;
    logic                victim_valid;
    logic [WAY_W-1:0]    victim_way;
    logic                flush_req;
    logic                busy;
    logic                flush_done;

    modport master (
        output touch_en, touch_set, touch_way, query_en, query_set, query_valid, flush_req,
        input  victim_valid, victim_way, busy, flush_done
    );

    modport slave (
        input  touch_en, touch_set, touch_way, query_en, query_set, query_valid, flush_req,
        output victim_valid, victim_way, busy, flush_done
    );
endinterface

// File: rtl/lru_set_ages.sv
// One set of true-LRU ages: touch update at the next edge, combinational victim from post-touch ages.
// No backpressure; init_en overrides any touch in the same cycle.
module lru_set_ages
    import lru_replacement_array_pkg::*;
#(
    parameter  int NUM_WAYS = DEF_NUM_WAYS,
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init_en,
    input  logic                touch_en,
    input  logic [WAY_W-1:0]    touch_way,
    input  logic [NUM_WAYS-1:0] query_valid,
    output logic [WAY_W-1:0]    victim_way
);

    logic [WAY_W-1:0] age_q [NUM_WAYS];
    logic [WAY_W-1:0] age_d [NUM_WAYS];

    // Ways younger than the touched one age by one; touching the MRU way is a no-op.
    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            age_d[w] = age_q[w];
            if (touch_en) begin
                if (WAY_W'(w) == touch_way)
                    age_d[w] = '0;
                else if (age_q[w] < age_q[touch_way])
                    age_d[w] = age_q[w] + WAY_W'(1);
            end
        end
    end

    // Lowest invalid way wins over the LRU way; ages are taken after this cycle's touch.
    always_comb begin
        victim_way = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (age_d[w] == WAY_W'(NUM_WAYS - 1))
                victim_way = WAY_W'(w);
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (!query_valid[w])
                victim_way = WAY_W'(w);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < NUM_WAYS; w++)
                age_q[w] <= WAY_W'(init_age(w, NUM_WAYS));
        end else if (init_en) begin
            for (int w = 0; w < NUM_WAYS; w++)
                age_q[w] <= WAY_W'(init_age(w, NUM_WAYS));
        end else begin
            for (int w = 0; w < NUM_WAYS; w++)
                age_q[w] <= age_d[w];
        end
    end

endmodule

// File: rtl/lru_replacement_array.sv
// Per-set true-LRU replacement state with victim query (1-cycle registered) and set-by-set flush.
// No backpressure: touch/query are dropped while busy or when coincident with flush_req.
module lru_replacement_array
    import lru_replacement_array_pkg::*;
#(
    parameter  int NUM_SETS = DEF_NUM_SETS,
    parameter  int NUM_WAYS = DEF_NUM_WAYS,
    localparam int SET_W    = $clog2(NUM_SETS),
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    lru_replacement_array_if.slave bus
);

    localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);
    localparam logic [SET_W-1:0] PRE_LAST = SET_W'(NUM_SETS - 2);

    flush_state_t     state_q;
    logic [SET_W-1:0] flush_cnt_q;
    logic             busy_q;
    logic             flush_done_q;
    logic             victim_valid_q;
    logic [WAY_W-1:0] victim_way_q;
    logic             accept;
    logic [WAY_W-1:0] set_victim [NUM_SETS];

    assign accept = (state_q == ST_IDLE) && !bus.flush_req;

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
        lru_set_ages #(.NUM_WAYS(NUM_WAYS)) u_set (
            .clk         (clk),
            .rst         (rst),
            .init_en     ((state_q == ST_FLUSH) && (flush_cnt_q == SET_W'(s))),
            .touch_en    (accept && bus.touch_en && (bus.touch_set == SET_W'(s))),
            .touch_way   (bus.touch_way),
            .query_valid (bus.query_valid),
            .victim_way  (set_victim[s])
        );
    end

    // flush_done is armed one cycle early so it lines up with the write of the last set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            flush_cnt_q    <= '0;
            busy_q         <= 1'b0;
            flush_done_q   <= 1'b0;
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
        end else begin
            victim_valid_q <= accept && bus.query_en;
            if (accept && bus.query_en)
                victim_way_q <= set_victim[bus.query_set];
            flush_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.flush_req) begin
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    flush_cnt_q <= flush_cnt_q + SET_W'(1);
                    if (flush_cnt_q == PRE_LAST)
                        flush_done_q <= 1'b1;
                    if (flush_cnt_q == LAST_SET) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.flush_done   = flush_done_q;
    assign bus.victim_valid = victim_valid_q;
    assign bus.victim_way   = victim_way_q;

endmodule

// File: tb/tb_lru_replacement_array.sv
// Bench for lru_replacement_array: directed scenarios plus random traffic against a
// recency-timestamp model of true LRU.
module tb_lru_replacement_array;

    localparam int NS = 64;
    localparam int NW = 4;
    localparam int SW = 6;
    localparam int WW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lru_replacement_array_if #(.NUM_SETS(NS), .NUM_WAYS(NW)) bus ();

    lru_replacement_array #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: larger stamp = more recently used; the LRU way has the smallest stamp.
    int unsigned stamp [NS][NW];
    int unsigned stamp_ctr;
    int          flush_left;
    bit          exp_vv;
    int          exp_vw;
    int          checks;
    int          failures;
    int          busy_cnt, done_cnt, done_at;

    task automatic check_eq(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    function automatic void model_init_set(input int s);
        for (int w = 0; w < NW; w++) stamp[s][w] = w;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NS; s++) model_init_set(s);
        flush_left = 0;
        exp_vv     = 1'b0;
        exp_vw     = 0;
    endfunction

    function automatic int model_victim(input int s, input logic [NW-1:0] v);
        int best;
        for (int w = 0; w < NW; w++)
            if (!v[w]) return w;
        best = 0;
        for (int w = 1; w < NW; w++)
            if (stamp[s][w] < stamp[s][best]) best = w;
        return best;
    endfunction

    // Called at a negedge: check the current outputs, drive one cycle of inputs, advance model.
    task automatic step(input bit te, input int ts, input int tw, input bit qe, input int qs,
                        input logic [NW-1:0] qv, input bit fr);
        check_eq("busy", int'(bus.busy), int'(flush_left > 0));
        check_eq("flush_done", int'(bus.flush_done), int'(flush_left == 1));
        check_eq("victim_valid", int'(bus.victim_valid), int'(exp_vv));
        if (exp_vv) check_eq("victim_way", int'(bus.victim_way), exp_vw);
        bus.touch_en    = te;
        bus.touch_set   = SW'(ts);
        bus.touch_way   = WW'(tw);
        bus.query_en    = qe;
        bus.query_set   = SW'(qs);
        bus.query_valid = qv;
        bus.flush_req   = fr;
        @(posedge clk);
        if (flush_left > 0) begin
            model_init_set(NS - flush_left);
            flush_left--;
            exp_vv = 1'b0;
        end else if (fr) begin
            flush_left = NS;
            exp_vv     = 1'b0;
        end else begin
            if (te) begin
                stamp_ctr++;
                stamp[ts][tw] = stamp_ctr;
            end
            exp_vv = qe;
            if (qe) exp_vw = model_victim(qs, qv);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 0, '1, 1'b0);
    endtask

    task automatic touch(input int s, input int w);
        step(1'b1, s, w, 1'b0, 0, '1, 1'b0);
    endtask

    task automatic query(input int s, input logic [NW-1:0] v);
        step(1'b0, 0, 0, 1'b1, s, v, 1'b0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        stamp_ctr  = 100;
        bus.touch_en = 1'b0; bus.touch_set = '0; bus.touch_way = '0;
        bus.query_en = 1'b0; bus.query_set = '0; bus.query_valid = '1;
        bus.flush_req = 1'b0;
        model_reset();

        #1;
        check_eq("rst_busy", int'(bus.busy), 0);
        check_eq("rst_done", int'(bus.flush_done), 0);
        check_eq("rst_vvalid", int'(bus.victim_valid), 0);
        check_eq("rst_vway", int'(bus.victim_way), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Fresh set: way 0 is LRU.
        query(5, 4'b1111);
        check_eq("q5_init", int'(bus.victim_way), 0);

        touch(5, 0); touch(5, 1); touch(5, 2);
        query(5, 4'b1111);
        check_eq("q5_after012", int'(bus.victim_way), 3);
        touch(5, 3);
        query(5, 4'b1111);
        check_eq("q5_after3", int'(bus.victim_way), 0);

        // Repeated MRU touch leaves ordering alone.
        touch(5, 3); touch(5, 3);
        query(5, 4'b1111);
        check_eq("q5_mru_retouch", int'(bus.victim_way), 0);

        query(9, 4'b1011);
        check_eq("q9_invalid", int'(bus.victim_way), 2);

        // Same-cycle touch and query of one set sees the touched ages.
        step(1'b1, 3, 0, 1'b1, 3, 4'b1111, 1'b0);
        check_eq("bypass_s3", int'(bus.victim_way), 1);

        // Different-set touch does not disturb the queried set.
        step(1'b1, 7, 0, 1'b1, 8, 4'b1111, 1'b0);
        check_eq("indep_s8", int'(bus.victim_way), 0);

        // Flush: coincident touch/query dropped, busy for NS cycles, traffic ignored.
        touch(10, 0); touch(11, 1); touch(12, 0); touch(63, 0);
        step(1'b1, 20, 0, 1'b1, 20, 4'b1111, 1'b1);
        busy_cnt = 0; done_cnt = 0; done_at = 0;
        for (int i = 0; i < 70; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.flush_done) begin
                done_cnt++;
                done_at = busy_cnt;
            end
            step(bit'($urandom_range(0, 1)), $urandom_range(0, NS - 1), $urandom_range(0, NW - 1),
                 bit'($urandom_range(0, 1)), $urandom_range(0, NS - 1), '1,
                 (i < 60) && ($urandom_range(0, 7) == 0));
        end
        check_eq("flush_busy_cycles", busy_cnt, NS);
        check_eq("flush_done_count", done_cnt, 1);
        check_eq("flush_done_pos", done_at, NS);
        idle();
        query(10, 4'b1111);
        check_eq("postflush_s10", int'(bus.victim_way), 0);
        query(63, 4'b1111);
        check_eq("postflush_s63", int'(bus.victim_way), 0);
        query(20, 4'b1111);
        check_eq("postflush_s20", int'(bus.victim_way), 0);

        // Random traffic concentrated on a few sets, occasional flushes and invalid ways.
        for (int i = 0; i < 600; i++) begin
            step(bit'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, NW - 1),
                 bit'($urandom_range(0, 1)), $urandom_range(0, 7),
                 ($urandom_range(0, 3) == 0) ? NW'($urandom) : 4'b1111,
                 $urandom_range(0, 79) == 0);
        end
        for (int i = 0; i < NS + 2; i++) idle();

        // Reset 10 cycles into a flush aborts it.
        touch(40, 0); touch(40, 1);
        step(1'b0, 0, 0, 1'b0, 0, '1, 1'b1);
        for (int i = 0; i < 10; i++) idle();
        check_eq("pre_abort_busy", int'(bus.busy), 1);
        rst = 1'b0;
        #1;
        check_eq("abort_busy", int'(bus.busy), 0);
        check_eq("abort_done", int'(bus.flush_done), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_busy_held", int'(bus.busy), 0);
        check_eq("abort_vvalid", int'(bus.victim_valid), 0);
        rst = 1'b1;
        for (int s = 0; s < NS; s++) begin
            query(s, 4'b1111);
            check_eq("abort_victim", int'(bus.victim_way), 0);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
